// File: rtl/decimal_key_debouncer.sv
// Decimal keypad front end: synchronises ten raw key lines, debounces
// press/release, rejects multi-key chords and emits a registered one-hot key.
module decimal_key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] keys_in,
  output logic [9:0] key_onehot,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_err
);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  logic [9:0]       s1;
  logic [9:0]       keys_sync;
  logic [9:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             sync_zero;
  logic             cand_one_hot;

  // saturating increment so a stuck count can never wrap
  assign cnt_inc      = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  assign sync_zero    = (keys_sync == '0);
  assign cand_one_hot = (cand != '0) && ((cand & (cand - 10'd1)) == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= '0;
      keys_sync  <= '0;
      cand       <= '0;
      cnt        <= '0;
      state      <= IDLE;
      key_onehot <= '0;
      key_valid  <= 1'b0;
      key_held   <= 1'b0;
      multi_err  <= 1'b0;
    end else begin
      s1        <= keys_in;
      keys_sync <= s1;
      key_valid <= 1'b0;
      multi_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!sync_zero) begin
            cand  <= keys_sync;
            cnt   <= CNT_ONE;
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (sync_zero) begin
            state <= IDLE;
          end else if (keys_sync != cand) begin
            cand <= keys_sync;
            cnt  <= CNT_ONE;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              if (cand_one_hot) begin
                key_onehot <= cand;
                key_valid  <= 1'b1;
                key_held   <= 1'b1;
                state      <= PRESSED;
              end else begin
                // release count starts fresh so a chord cannot lock us out
                multi_err <= 1'b1;
                cnt       <= '0;
                state     <= RELEASE;
              end
            end
          end
        end
        PRESSED: begin
          if (keys_sync != cand) begin
            cnt      <= '0;
            key_held <= 1'b0;
            state    <= RELEASE;
          end
        end
        RELEASE: begin
          if (sync_zero) begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state <= IDLE;
            end
          end else begin
            cnt <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decimal_key_debouncer.sv
// Bench for decimal_key_debouncer: directed vector table, scenario
// sequences and randomized stimulus against a run-length reference model.
module tb_decimal_key_debouncer;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] keys_in = '0;
  logic [9:0] key_onehot;
  logic       key_valid;
  logic       key_held;
  logic       multi_err;

  int checks = 0;
  int errors = 0;

  decimal_key_debouncer #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .keys_in(keys_in),
    .key_onehot(key_onehot),
    .key_valid(key_valid),
    .key_held(key_held),
    .multi_err(multi_err)
  );

  always #5 clk = ~clk;

  // reference model: sync pipe, run lengths and a three-way mode
  localparam int M_WAIT = 0;
  localparam int M_HELD = 1;
  localparam int M_LOCK = 2;

  logic [9:0] m_s1 = '0;
  logic [9:0] m_sync = '0;
  logic [9:0] m_prev = '0;
  logic [9:0] m_key = '0;
  int         m_run = 0;
  int         m_zc = 0;
  int         m_mode = M_WAIT;
  logic [9:0] m_onehot = '0;
  logic       m_valid = 1'b0;
  logic       m_held = 1'b0;
  logic       m_multi = 1'b0;

  task automatic model_step();
    logic [9:0] v;
    if (rst) begin
      m_s1 = '0; m_sync = '0; m_prev = '0; m_key = '0;
      m_run = 0; m_zc = 0; m_mode = M_WAIT;
      m_onehot = '0; m_valid = 1'b0; m_held = 1'b0; m_multi = 1'b0;
      return;
    end
    v = m_sync;
    m_sync = m_s1;
    m_s1 = keys_in;
    if (v == m_prev) m_run = (m_run < 1000) ? m_run + 1 : m_run;
    else m_run = 1;
    m_prev = v;
    m_valid = 1'b0;
    m_multi = 1'b0;
    if (m_mode == M_WAIT) begin
      if (v != 0 && m_run == DC) begin
        if ($countones(v) == 1) begin
          m_onehot = v; m_key = v; m_valid = 1'b1;
          m_held = 1'b1; m_mode = M_HELD;
        end else begin
          m_multi = 1'b1; m_zc = 0; m_mode = M_LOCK;
        end
      end
    end else if (m_mode == M_HELD) begin
      if (v != m_key) begin
        m_held = 1'b0; m_zc = 0; m_mode = M_LOCK;
      end
    end else begin
      if (v == 0) begin
        m_zc++;
        if (m_zc == DC) m_mode = M_WAIT;
      end else begin
        m_zc = 0;
      end
    end
  endtask

  int tcnt, n_valid, n_multi, t_valid, t_drop;

  task automatic clr();
    tcnt = 0; n_valid = 0; n_multi = 0; t_valid = -1; t_drop = -1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    tcnt++;
    if (key_valid) begin
      n_valid++;
      if (t_valid < 0) t_valid = tcnt;
    end
    if (multi_err) n_multi++;
    if (!key_held && t_drop < 0) t_drop = tcnt;
    checks++;
    if ({key_valid, multi_err, key_held, key_onehot} !==
        {m_valid, m_multi, m_held, m_onehot}) begin
      errors++;
      $display("FAIL model t=%0t got v=%b m=%b h=%b oh=%h want v=%b m=%b h=%b oh=%h",
               $time, key_valid, multi_err, key_held, key_onehot,
               m_valid, m_multi, m_held, m_onehot);
    end
  endtask

  task automatic hold(input logic [9:0] k, input int n);
    keys_in = k;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic int enc(input logic [9:0] a);
    for (int i = 0; i < 10; i++) if (a[i]) return i;
    return 15;
  endfunction

  typedef struct {
    logic       rst;
    logic [9:0] keys;
    logic       valid;
    logic       held;
    logic       multi;
    logic [9:0] onehot;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(logic r, logic [9:0] k, logic v, logic h,
                              logic [9:0] oh);
    vec_t x;
    x.rst = r; x.keys = k; x.valid = v; x.held = h; x.multi = 1'b0;
    x.onehot = oh;
    return x;
  endfunction

  initial begin
    tbl[0]  = mk(1'b1, 10'h000, 1'b0, 1'b0, 10'h000);
    tbl[1]  = mk(1'b0, 10'h008, 1'b0, 1'b0, 10'h000);
    tbl[2]  = mk(1'b0, 10'h008, 1'b0, 1'b0, 10'h000);
    tbl[3]  = mk(1'b0, 10'h008, 1'b0, 1'b0, 10'h000);
    tbl[4]  = mk(1'b0, 10'h008, 1'b0, 1'b0, 10'h000);
    tbl[5]  = mk(1'b0, 10'h008, 1'b0, 1'b0, 10'h000);
    tbl[6]  = mk(1'b0, 10'h008, 1'b1, 1'b1, 10'h008);
    tbl[7]  = mk(1'b0, 10'h008, 1'b0, 1'b1, 10'h008);
    tbl[8]  = mk(1'b0, 10'h000, 1'b0, 1'b1, 10'h008);
    tbl[9]  = mk(1'b0, 10'h000, 1'b0, 1'b1, 10'h008);
    tbl[10] = mk(1'b0, 10'h000, 1'b0, 1'b0, 10'h008);
    tbl[11] = mk(1'b0, 10'h000, 1'b0, 1'b0, 10'h008);
    clr();

    // clean press, cycle by cycle
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst;
      keys_in = tbl[i].keys;
      tick();
      checks++;
      if ({key_valid, key_held, multi_err, key_onehot} !==
          {tbl[i].valid, tbl[i].held, tbl[i].multi, tbl[i].onehot}) begin
        errors++;
        $display("FAIL vec%0d got v=%b h=%b m=%b oh=%h want v=%b h=%b m=%b oh=%h",
                 i, key_valid, key_held, multi_err, key_onehot,
                 tbl[i].valid, tbl[i].held, tbl[i].multi, tbl[i].onehot);
      end
      if (i == 6) chk("encoder_clean", enc(key_onehot), 3);
    end

    // bounce
    hold(10'h000, 8);
    clr();
    for (int i = 0; i < 3; i++) begin
      hold(10'h020, 2);
      hold(10'h000, 2);
    end
    chk("bounce_no_valid", n_valid, 0);
    clr();
    hold(10'h020, 10);
    chk("bounce_latency", t_valid, 6);
    chk("bounce_onehot", int'(key_onehot), 'h020);
    chk("bounce_held", int'(key_held), 1);

    // multi-key chord
    hold(10'h000, 8);
    clr();
    hold(10'h081, 10);
    chk("multi_pulses", n_multi, 1);
    chk("multi_no_valid", n_valid, 0);
    chk("multi_keeps_onehot", int'(key_onehot), 'h020);
    hold(10'h000, 8);
    clr();
    hold(10'h001, 10);
    chk("after_multi_valid", n_valid, 1);
    chk("after_multi_onehot", int'(key_onehot), 'h001);
    chk("encoder_zero", enc(key_onehot), 0);

    // repeat lockout
    hold(10'h000, 8);
    clr();
    hold(10'h200, 10);
    chk("lock_first", n_valid, 1);
    clr();
    hold(10'h000, 2);
    hold(10'h200, 10);
    chk("lock_short_release", n_valid, 0);
    clr();
    hold(10'h000, 6);
    hold(10'h200, 10);
    chk("lock_long_release", n_valid, 1);

    // second key added while pressed
    hold(10'h000, 8);
    clr();
    hold(10'h002, 10);
    chk("second_first", n_valid, 1);
    clr();
    hold(10'h022, 10);
    chk("second_held_drop", t_drop, 3);
    chk("second_no_valid", n_valid, 0);
    chk("second_no_multi", n_multi, 0);
    chk("second_onehot", int'(key_onehot), 'h002);

    // reset mid-debounce
    hold(10'h000, 8);
    clr();
    hold(10'h010, 3);
    rst = 1'b1;
    tick();
    chk("rst_outputs", int'({key_valid, multi_err, key_held, key_onehot}), 0);
    rst = 1'b0;
    clr();
    hold(10'h010, 10);
    chk("rst_latency", t_valid, 6);
    chk("rst_onehot", int'(key_onehot), 'h010);

    // randomized segments against the model
    for (int s = 0; s < 300; s++) begin
      logic [9:0] pat;
      int sel;
      if ($urandom_range(0, 99) < 3) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      sel = $urandom_range(0, 3);
      if (sel == 0) pat = '0;
      else if (sel == 3) pat = 10'($urandom) | 10'h001 | 10'h100;
      else pat = 10'(1) << $urandom_range(0, 9);
      hold(pat, $urandom_range(1, 12));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
